// File: rtl/sdram_emu.sv
// Block-RAM backed SDR SDRAM responder: decodes controller command pins, tracks
// banks/mode, serves CAS-latency read bursts and byte-masked write bursts.
module sdram_emu #(
    parameter int MEM_AW = 12,
    parameter int TRCD   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_dqm,
    input  logic [15:0] sd_data_in,
    output logic [15:0] sd_data_out,
    output logic        sd_data_oe,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_count,
    output logic        err
);
    typedef enum logic [1:0] {B_IDLE, B_RD, B_WR} bst_e;

    localparam logic [7:0] TRCD_V  = 8'(TRCD);
    localparam logic [7:0] TRCD_M1 = 8'((TRCD > 0) ? TRCD - 1 : 0);

    logic [3:0]  cmd;
    logic        is_act, is_rd, is_wr, is_bt, is_pre, is_ref, is_lmr;
    logic        bank_open, trcd_ok, rw_go, stop, bst_live, cl3, err_d;
    logic [2:0]  bl_mask, cmd_mask;
    logic [MEM_AW-1:0] cmd_addr, iss_addr, rd_sel;
    logic        iss_rd, iss_wr, iss_cl3;

    logic [3:0]  open_q;
    logic [12:0] row_q [4];
    logic [7:0]  trcd_q [4];
    logic [12:0] mode_q;
    logic [15:0] rcnt_q;
    logic        err_q;
    bst_e        bst_q;
    logic [1:0]  bst_ba_q;
    logic [12:0] bst_row_q;
    logic [9:0]  bst_col_q;
    logic [2:0]  bst_mask_q, bst_left_q;
    logic        bst_cl3_q;
    logic        p0_v_q, p0_cl3_q, p1_v_q, oe_q;
    logic [MEM_AW-1:0] p0_a_q, p1_a_q;
    logic [15:0] rdata_q;
    logic [15:0] mem [2**MEM_AW];

    function automatic logic [MEM_AW-1:0] waddr(input logic [1:0] b,
                                                input logic [12:0] r,
                                                input logic [9:0] c);
        return (MEM_AW)'({b, r, c});
    endfunction

    // Sequential increment that wraps inside the burst-aligned block.
    function automatic logic [9:0] ncol(input logic [9:0] c, input logic [2:0] m);
        return (c & ~{7'd0, m}) | ((c + 10'd1) & {7'd0, m});
    endfunction

    assign cmd    = {sd_cs, sd_ras, sd_cas, sd_we};
    assign is_act = cmd == 4'b0011;
    assign is_rd  = cmd == 4'b0101;
    assign is_wr  = cmd == 4'b0100;
    assign is_bt  = cmd == 4'b0110;
    assign is_pre = cmd == 4'b0010;
    assign is_ref = cmd == 4'b0001;
    assign is_lmr = cmd == 4'b0000;

    assign bank_open = open_q[sd_ba];
    assign trcd_ok   = trcd_q[sd_ba] >= TRCD_M1;
    assign rw_go     = (is_rd || is_wr) && bank_open;
    assign cl3       = mode_q[6:4] != 3'd2;
    assign cmd_addr  = waddr(sd_ba, row_q[sd_ba], sd_addr[9:0]);
    assign cmd_mask  = (is_wr && mode_q[9]) ? 3'd0 : bl_mask;
    assign stop      = is_bt || rw_go ||
                       (is_pre && (sd_addr[10] || sd_ba == bst_ba_q));
    assign bst_live  = (bst_q != B_IDLE) && !stop;

    always_comb begin
        unique case (mode_q[2:0])
            3'd1:       bl_mask = 3'd1;
            3'd2:       bl_mask = 3'd3;
            3'd3, 3'd7: bl_mask = 3'd7;
            default:    bl_mask = 3'd0;
        endcase
    end

    always_comb begin
        iss_rd   = 1'b0;
        iss_wr   = 1'b0;
        iss_addr = cmd_addr;
        iss_cl3  = cl3;
        if (rw_go) begin
            iss_rd = is_rd;
            iss_wr = is_wr;
        end else if (bst_live) begin
            iss_rd   = bst_q == B_RD;
            iss_wr   = bst_q == B_WR;
            iss_addr = waddr(bst_ba_q, bst_row_q, bst_col_q);
            iss_cl3  = bst_cl3_q;
        end
    end

    assign err_d = (is_act && bank_open) ||
                   ((is_ref || is_lmr) && (|open_q)) ||
                   (is_lmr && sd_addr[6:4] != 3'd2 && sd_addr[6:4] != 3'd3) ||
                   ((is_rd || is_wr) && (!bank_open || !trcd_ok));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            open_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                row_q[i]  <= '0;
                trcd_q[i] <= TRCD_V;
            end
            mode_q     <= 13'h0230;
            rcnt_q     <= '0;
            err_q      <= 1'b0;
            bst_q      <= B_IDLE;
            bst_ba_q   <= '0;
            bst_row_q  <= '0;
            bst_col_q  <= '0;
            bst_mask_q <= '0;
            bst_left_q <= '0;
            bst_cl3_q  <= 1'b1;
            p0_v_q     <= 1'b0;
            p0_cl3_q   <= 1'b1;
            p0_a_q     <= '0;
            p1_v_q     <= 1'b0;
            p1_a_q     <= '0;
            oe_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (trcd_q[i] < TRCD_V) trcd_q[i] <= trcd_q[i] + 8'd1;
                if (is_act && sd_ba == 2'(i)) begin
                    open_q[i] <= 1'b1;
                    row_q[i]  <= sd_addr;
                    trcd_q[i] <= '0;
                end
                if (is_pre && (sd_addr[10] || sd_ba == 2'(i)))
                    open_q[i] <= 1'b0;
            end
            if (is_lmr) mode_q <= sd_addr;
            if (is_ref) rcnt_q <= rcnt_q + 16'd1;
            err_q <= err_d;
            if (rw_go) begin
                bst_q      <= (cmd_mask == 3'd0) ? B_IDLE : (is_rd ? B_RD : B_WR);
                bst_ba_q   <= sd_ba;
                bst_row_q  <= row_q[sd_ba];
                bst_col_q  <= ncol(sd_addr[9:0], cmd_mask);
                bst_mask_q <= cmd_mask;
                bst_left_q <= cmd_mask;
                bst_cl3_q  <= cl3;
            end else if (bst_live) begin
                bst_col_q  <= ncol(bst_col_q, bst_mask_q);
                bst_left_q <= bst_left_q - 3'd1;
                if (bst_left_q == 3'd1) bst_q <= B_IDLE;
            end else if (stop) begin
                bst_q <= B_IDLE;
            end
            // CL2 words leave from stage 0, CL3 words take one more stage.
            p0_v_q   <= iss_rd;
            p0_a_q   <= iss_addr;
            p0_cl3_q <= iss_cl3;
            p1_v_q   <= p0_v_q && p0_cl3_q;
            p1_a_q   <= p0_a_q;
            oe_q     <= p1_v_q || (p0_v_q && !p0_cl3_q);
        end
    end

    assign rd_sel = p1_v_q ? p1_a_q : p0_a_q;

    always_ff @(posedge clk) begin
        rdata_q <= mem[rd_sel];
        if (iss_wr && resetn) begin
            if (!sd_dqm[0]) mem[iss_addr][7:0]  <= sd_data_in[7:0];
            if (!sd_dqm[1]) mem[iss_addr][15:8] <= sd_data_in[15:8];
        end
    end

    assign sd_data_out   = oe_q ? rdata_q : 16'h0000;
    assign sd_data_oe    = oe_q;
    assign mode_reg      = mode_q;
    assign refresh_count = rcnt_q;
    assign err           = err_q;
endmodule
